// File: rtl/jt03_wr_seq.sv
// jt03_wr_seq: queued (register, value) writer for the YM2203 bus interface.
// Polls the busy flag, then issues the address strobe and the data strobe with programmable timing.
module jt03_wr_seq #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int WR_PULSE = 2,
  parameter int ADDR_GAP = 4,
  parameter int DATA_GAP = 24,
  parameter int TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [7:0]    cmd_reg,
  input  logic [7:0]    cmd_val,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  output logic [AW:0]   fifo_cnt,
  output logic          idle,
  input  logic          err_clr,
  output logic          timeout_err,
  output logic [7:0]    ym_din,
  output logic          ym_addr,
  output logic          ym_cs_n,
  output logic          ym_wr_n,
  input  logic [7:0]    ym_dout
);

  localparam int CMAX1 = (TIMEOUT > DATA_GAP) ? TIMEOUT : DATA_GAP;
  localparam int CMAX2 = (ADDR_GAP > WR_PULSE) ? ADDR_GAP : WR_PULSE;
  localparam int CMAX  = (CMAX1 > CMAX2) ? CMAX1 : CMAX2;
  localparam int CW    = $clog2(CMAX + 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_AWR,
    S_AGAP,
    S_DWR,
    S_DGAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    din_q, din_d;
  logic          addr_q, addr_d;
  logic          cs_n_q, cs_n_d;
  logic          wr_n_q, wr_n_d;
  logic          err_q, err_d;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fcnt_q, fcnt_d;
  logic          push, pop;
  logic [7:0]    head_reg, head_val;
  logic          unused_dout;

  assign unused_dout = ^ym_dout[6:0];

  assign cmd_ready   = (fcnt_q != FULL_CNT);
  assign push        = cmd_valid && cmd_ready;
  assign head_reg    = mem_q[rd_ptr_q][15:8];
  assign head_val    = mem_q[rd_ptr_q][7:0];

  assign fifo_cnt    = fcnt_q;
  assign idle        = (fcnt_q == '0) && (state_q == S_IDLE);
  assign timeout_err = err_q;
  assign ym_din      = din_q;
  assign ym_addr     = addr_q;
  assign ym_cs_n     = cs_n_q;
  assign ym_wr_n     = wr_n_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_reg, cmd_val};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    addr_d  = addr_q;
    cs_n_d  = cs_n_q;
    wr_n_d  = wr_n_q;
    err_d   = err_q;
    pop     = 1'b0;
    if (err_clr) err_d = 1'b0;
    if (cen) begin
      unique case (state_q)
        S_IDLE: begin
          cs_n_d = 1'b1;
          wr_n_d = 1'b1;
          if (fcnt_q != '0) begin
            // register byte goes on the bus with cs_n so it is stable before wr_n falls
            state_d = S_POLL;
            cnt_d   = '0;
            addr_d  = 1'b0;
            din_d   = head_reg;
            cs_n_d  = 1'b0;
          end
        end
        S_POLL: begin
          if (!ym_dout[7]) begin
            state_d = S_AWR;
            cnt_d   = '0;
            wr_n_d  = 1'b0;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_AWR;
            cnt_d   = '0;
            wr_n_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_AWR: begin
          if (cnt_q == CW'(WR_PULSE - 1)) begin
            state_d = S_AGAP;
            cnt_d   = '0;
            cs_n_d  = 1'b1;
            wr_n_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_AGAP: begin
          if (cnt_q == CW'(ADDR_GAP - 1)) begin
            state_d = S_DWR;
            cnt_d   = '0;
            cs_n_d  = 1'b0;
            wr_n_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DWR: begin
          if (cnt_q == CW'(WR_PULSE - 1)) begin
            state_d = S_DGAP;
            cnt_d   = '0;
            cs_n_d  = 1'b1;
            wr_n_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DGAP: begin
          if (cnt_q == CW'(DATA_GAP - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pop     = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          wr_n_d  = 1'b1;
        end
      endcase
      // switch to the data phase on the last idle gap cycle so the data strobe falls on settled pins
      if (state_d == S_AGAP && cnt_d == CW'(ADDR_GAP - 1)) begin
        addr_d = 1'b1;
        din_d  = head_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      din_q    <= '0;
      addr_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      din_q    <= din_d;
      addr_q   <= addr_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_jt03_wr_seq.sv
// Bench for jt03_wr_seq: directed command stream with a strobe scoreboard and cycle-exact pin checks.
module tb_jt03_wr_seq;

  logic       clk = 1'b0;
  logic       rst, cen, cmd_valid, cmd_ready, idle, err_clr, timeout_err;
  logic [7:0] cmd_reg, cmd_val, ym_din, ym_dout;
  logic [4:0] fifo_cnt;
  logic       ym_addr, ym_cs_n, ym_wr_n;

  int n_total = 0;
  int n_bad   = 0;
  int n_seen  = 0;
  logic [8:0] sb[$];

  jt03_wr_seq #(
    .DEPTH(16), .AW(4), .WR_PULSE(2), .ADDR_GAP(4), .DATA_GAP(24), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .cmd_reg(cmd_reg), .cmd_val(cmd_val), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .fifo_cnt(fifo_cnt), .idle(idle), .err_clr(err_clr), .timeout_err(timeout_err),
    .ym_din(ym_din), .ym_addr(ym_addr), .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n),
    .ym_dout(ym_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one command accepted at the posedge between two negedges; expectations queued first
  task automatic push_cmd(input logic [7:0] r, input logic [7:0] v);
    sb.push_back({1'b0, r});
    sb.push_back({1'b1, v});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_reg = r; cmd_val = v;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (!idle && c < maxc);
    chk(nm, 32'(idle), 32'd1);
  endtask

  function automatic logic [10:0] t2_bus(input int k);
    if (k == 1)      return {1'b0, 1'b1, 1'b0, 8'h28};
    else if (k <= 3) return {1'b0, 1'b0, 1'b0, 8'h28};
    else if (k <= 6) return {1'b1, 1'b1, 1'b0, 8'h28};
    else if (k == 7) return {1'b1, 1'b1, 1'b1, 8'hF0};
    else if (k <= 9) return {1'b0, 1'b0, 1'b1, 8'hF0};
    else             return {1'b1, 1'b1, 1'b1, 8'hF0};
  endfunction

  // monitor: every falling wr_n is a strobe, checked against the scoreboard and its timing
  logic       m_prev_wr;
  logic [8:0] m_prev_bus, m_exp;
  int         m_low, m_gap;
  initial begin
    m_prev_wr = 1'b1; m_prev_bus = '0; m_low = 0; m_gap = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        m_prev_wr = 1'b1; m_low = 0; m_gap = 0;
      end else begin
        if (m_prev_wr && !ym_wr_n) begin
          n_seen++;
          chk("setup", 32'({ym_addr, ym_din}), 32'(m_prev_bus));
          chk("cs_low", 32'(ym_cs_n), 32'd0);
          if (sb.size() == 0) begin
            chk("strobe_unexpected", 32'({ym_addr, ym_din}), 32'h1FF);
          end else begin
            m_exp = sb.pop_front();
            chk("strobe", 32'({ym_addr, ym_din}), 32'(m_exp));
          end
          if (ym_addr) chk("addr_gap", 32'(m_gap), 32'd4);
          m_low = 1;
        end else if (!ym_wr_n) begin
          m_low++;
        end else if (!m_prev_wr) begin
          chk("pulse", 32'(m_low), 32'd2);
          m_gap = 1;
        end else begin
          m_gap++;
        end
      end
      m_prev_wr  = ym_wr_n;
      m_prev_bus = {ym_addr, ym_din};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any_low;
    rst = 1'b1; cen = 1'b1; cmd_valid = 1'b1; cmd_reg = 8'h11; cmd_val = 8'h22;
    err_clr = 1'b0; ym_dout = 8'h00;

    // reset with cmd_valid held high
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pins", 32'({ym_cs_n, ym_wr_n, ym_addr, ym_din}), 32'h600);
    chk("rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;

    // single write, exact cycle shape
    push_cmd(8'h28, 8'hF0);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      chk("t2_bus", 32'({ym_cs_n, ym_wr_n, ym_addr, ym_din}), 32'(t2_bus(k)));
      if (k == 33) chk("t2_busy", 32'({idle, fifo_cnt}), 32'h01);
      if (k == 34) chk("t2_idle", 32'({idle, fifo_cnt}), 32'h20);
    end

    // busy for 10 samples, then clear
    @(negedge clk); ym_dout = 8'h80;
    push_cmd(8'hA4, 8'h3C);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      chk("t3_hold", 32'({ym_cs_n, ym_wr_n}), 32'h1);
    end
    @(negedge clk); ym_dout = 8'h00;
    @(posedge clk); #1;
    chk("t3_go", 32'({ym_cs_n, ym_wr_n, ym_din}), 32'h0A4);
    wait_idle(100, "t3_idle");
    chk("t3_err", 32'(timeout_err), 32'd0);

    // busy stuck: forced write after 255 polls
    @(negedge clk); ym_dout = 8'h80;
    push_cmd(8'h30, 8'h71);
    repeat (254) @(posedge clk);
    @(posedge clk); #1;
    chk("t4_before", 32'({timeout_err, ym_wr_n}), 32'h1);
    @(posedge clk); #1;
    chk("t4_forced", 32'({timeout_err, ym_wr_n}), 32'h2);
    wait_idle(100, "t4_idle");
    chk("t4_sticky", 32'(timeout_err), 32'd1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("t4_clr", 32'(timeout_err), 32'd0);
    ym_dout = 8'h00;

    // fill with cen low, 17th push refused, then drain across the pointer wrap
    @(negedge clk); cen = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) begin
        sb.push_back({1'b0, 8'(8'h80 + i)});
        sb.push_back({1'b1, 8'(8'h10 + i)});
      end
      cmd_valid = 1'b1; cmd_reg = 8'(8'h80 + i); cmd_val = 8'(8'h10 + i);
      @(negedge clk);
      if (i == 14) chk("t5_ready15", 32'(cmd_ready), 32'd1);
    end
    cmd_valid = 1'b0;
    chk("t5_cnt", 32'(fifo_cnt), 32'd16);
    chk("t5_ready", 32'(cmd_ready), 32'd0);
    chk("t5_frozen", 32'({idle, ym_cs_n, ym_wr_n}), 32'h3);
    cen = 1'b1;
    wait_idle(1000, "t5_idle");
    chk("t5_drain", 32'(sb.size()), 32'd0);

    // reset during the data strobe
    push_cmd(8'h40, 8'h55);
    begin
      int c = 0;
      do begin
        @(posedge clk); #1;
        c++;
      end while (!(ym_wr_n == 1'b0 && ym_addr == 1'b1) && c < 100);
      chk("t6_reach", 32'({ym_wr_n, ym_addr, ym_din}), 32'h155);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_pins", 32'({ym_cs_n, ym_wr_n}), 32'h3);
    chk("t6_cnt", 32'(fifo_cnt), 32'd0);
    @(negedge clk); rst = 1'b0;
    any_low = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (!ym_wr_n || !ym_cs_n) any_low = 1'b1;
    end
    chk("t6_quiet", 32'(any_low), 32'd0);
    chk("t6_idle", 32'({idle, fifo_cnt}), 32'h20);
    chk("strobes", 32'(n_seen), 32'd40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
